// File: rtl/alu_adder_hold_if.sv
// Control, operand and flag bundle between the ALU adder-hold core and its sequencer.
// Bus drives (sb_out/adl_out) stay as plain ports so tri-state resolution happens at the module boundary.
interface alu_adder_hold_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       carry_in;
  logic       bcd;
  logic       sub;
  logic       add_sb;
  logic       add_adl;
  logic       acr;
  logic       avr;
  logic       busy;
  logic       done;

  modport master (
    output start, op, a_in, b_in, carry_in, bcd, sub, add_sb, add_adl,
    input  acr, avr, busy, done
  );

  modport slave (
    input  start, op, a_in, b_in, carry_in, bcd, sub, add_sb, add_adl,
    output acr, avr, busy, done
  );
endinterface

// File: rtl/alu_adder_hold.sv
// ALU core with adder hold register: binary stage on start, optional one-cycle BCD
// correction stage, and tri-state drive of the held result onto SB and ADL.
module alu_adder_hold (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_adder_hold_if.slave        bus,
  output wire  [7:0]             sb_out,
  output wire  [7:0]             adl_out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADJ  = 1'b1
  } state_t;

  localparam logic [2:0] OP_SUMS = 3'd0;
  localparam logic [2:0] OP_ANDS = 3'd1;
  localparam logic [2:0] OP_EORS = 3'd2;
  localparam logic [2:0] OP_ORS  = 3'd3;
  localparam logic [2:0] OP_SRS  = 3'd4;

  state_t     r_state;
  logic [7:0] r_hold;
  logic       r_acr;
  logic       r_avr;
  logic       r_hc;
  logic       r_c;
  logic       r_sub;
  logic       r_busy;
  logic       r_done;

  // Binary stage, evaluated from the live operand inputs
  logic [8:0] w_sum9;
  logic [4:0] w_low5;
  logic [7:0] w_bin_hold;
  logic       w_bin_acr;
  logic       w_bin_avr;
  logic       w_is_dec;

  assign w_sum9 = {1'b0, bus.a_in} + {1'b0, bus.b_in} + {8'd0, bus.carry_in};
  assign w_low5 = {1'b0, bus.a_in[3:0]} + {1'b0, bus.b_in[3:0]} + {4'd0, bus.carry_in};
  assign w_is_dec = (bus.op == OP_SUMS) && bus.bcd;

  always_comb begin
    w_bin_hold = 8'h00;
    w_bin_acr  = 1'b0;
    w_bin_avr  = 1'b0;
    case (bus.op)
      OP_SUMS: begin
        w_bin_hold = w_sum9[7:0];
        w_bin_acr  = w_sum9[8];
        w_bin_avr  = (bus.a_in[7] == bus.b_in[7]) && (w_sum9[7] != bus.a_in[7]);
      end
      OP_ANDS: w_bin_hold = bus.a_in & bus.b_in;
      OP_EORS: w_bin_hold = bus.a_in ^ bus.b_in;
      OP_ORS:  w_bin_hold = bus.a_in | bus.b_in;
      OP_SRS: begin
        w_bin_hold = {bus.carry_in, bus.a_in[7:1]};
        w_bin_acr  = bus.a_in[0];
      end
      default: begin
        w_bin_hold = 8'h00;
      end
    endcase
  end

  // Decimal correction stage, evaluated from the held binary result
  logic       w_add_lowfix;
  logic [8:0] w_add_t;
  logic       w_add_highfix;
  logic [7:0] w_add_hold;
  logic [7:0] w_sub_hold;
  logic [7:0] w_adj_hold;
  logic       w_adj_acr;

  assign w_add_lowfix  = r_hc | (r_hold[3:0] > 4'd9);
  assign w_add_t       = {1'b0, r_hold} + (w_add_lowfix ? 9'h006 : 9'h000);
  assign w_add_highfix = r_c | w_add_t[8] | (w_add_t[7:4] > 4'd9);
  assign w_add_hold    = w_add_t[7:0] + (w_add_highfix ? 8'h60 : 8'h00);
  // Subtract correction keys off the binary carries only; acr is the binary borrow-not
  assign w_sub_hold    = r_hold - (r_hc ? 8'h00 : 8'h06) - (r_c ? 8'h00 : 8'h60);
  assign w_adj_hold    = r_sub ? w_sub_hold : w_add_hold;
  assign w_adj_acr     = r_sub ? r_c : w_add_highfix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hold  <= 8'h00;
      r_acr   <= 1'b0;
      r_avr   <= 1'b0;
      r_hc    <= 1'b0;
      r_c     <= 1'b0;
      r_sub   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_hold <= w_bin_hold;
            r_acr  <= w_bin_acr;
            r_avr  <= w_bin_avr;
            r_hc   <= (bus.op == OP_SUMS) ? w_low5[4] : 1'b0;
            r_c    <= (bus.op == OP_SUMS) ? w_sum9[8] : 1'b0;
            r_sub  <= bus.sub;
            if (w_is_dec) begin
              r_state <= ST_ADJ;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        ST_ADJ: begin
          r_hold  <= w_adj_hold;
          r_acr   <= w_adj_acr;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acr  = r_acr;
  assign bus.avr  = r_avr;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  assign sb_out  = bus.add_sb  ? r_hold : 8'bzzzz_zzzz;
  assign adl_out = bus.add_adl ? r_hold : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_alu_adder_hold.sv
// Directed-vector bench for alu_adder_hold: hand-computed results for binary,
// decimal, logic/shift ops, reset abort and start handshake behaviour.
module tb_alu_adder_hold;

  logic       clk;
  logic       rst_n;
  wire  [7:0] sb_out;
  wire  [7:0] adl_out;
  int         n_cmp;
  int         n_err;

  alu_adder_hold_if u_if ();

  alu_adder_hold u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (u_if.slave),
    .sb_out  (sb_out),
    .adl_out (adl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic set_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic bcd, input logic sub);
    u_if.op       = op;
    u_if.a_in     = a;
    u_if.b_in     = b;
    u_if.carry_in = cin;
    u_if.bcd      = bcd;
    u_if.sub      = sub;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; outputs are sampled 1 time unit after that edge
  task automatic pulse(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic bcd, input logic sub);
    set_op(op, a, b, cin, bcd, sub);
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.start   = 1'b0;
    u_if.add_sb  = 1'b0;
    u_if.add_adl = 1'b1;
    set_op(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_done", {31'd0, u_if.done}, 32'd0);
    check("rst_hold", {24'd0, adl_out}, 32'h00);

    // Binary add with signed overflow
    pulse(3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
    check("badd_done", {31'd0, u_if.done}, 32'd1);
    check("badd_hold", {24'd0, adl_out}, 32'hA0);
    check("badd_acr", {31'd0, u_if.acr}, 32'd0);
    check("badd_avr", {31'd0, u_if.avr}, 32'd1);
    check("sb_disabled", {31'd0, sb_out !== 8'hA0}, 32'd1);
    u_if.add_sb = 1'b1;
    #1;
    check("sb_enabled", {24'd0, sb_out}, 32'hA0);
    tick();
    check("badd_done_drop", {31'd0, u_if.done}, 32'd0);
    check("badd_hold_keep", {24'd0, sb_out}, 32'hA0);

    // Decimal add 58+46+1 = 105
    pulse(3'd0, 8'h58, 8'h46, 1'b1, 1'b1, 1'b0);
    check("dadd1_busy", {31'd0, u_if.busy}, 32'd1);
    check("dadd1_done0", {31'd0, u_if.done}, 32'd0);
    tick();
    check("dadd1_done", {31'd0, u_if.done}, 32'd1);
    check("dadd1_busy0", {31'd0, u_if.busy}, 32'd0);
    check("dadd1_hold", {24'd0, sb_out}, 32'h05);
    check("dadd1_acr", {31'd0, u_if.acr}, 32'd1);
    check("dadd1_avr", {31'd0, u_if.avr}, 32'd1);
    tick();

    // Decimal add 19+28 = 47, half-carry correction only
    pulse(3'd0, 8'h19, 8'h28, 1'b0, 1'b1, 1'b0);
    tick();
    check("dadd2_hold", {24'd0, sb_out}, 32'h47);
    check("dadd2_acr", {31'd0, u_if.acr}, 32'd0);
    tick();

    // Decimal subtract 42-15 = 27
    pulse(3'd0, 8'h42, 8'hEA, 1'b1, 1'b1, 1'b1);
    tick();
    check("dsub1_hold", {24'd0, sb_out}, 32'h27);
    check("dsub1_acr", {31'd0, u_if.acr}, 32'd1);
    tick();

    // Decimal subtract 15-42 = 73 with borrow
    pulse(3'd0, 8'h15, 8'hBD, 1'b1, 1'b1, 1'b1);
    tick();
    check("dsub2_hold", {24'd0, sb_out}, 32'h73);
    check("dsub2_acr", {31'd0, u_if.acr}, 32'd0);
    tick();

    // Shift right, logic, reserved op
    pulse(3'd4, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
    check("srs_hold", {24'd0, sb_out}, 32'hC0);
    check("srs_acr", {31'd0, u_if.acr}, 32'd1);
    pulse(3'd1, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0);
    check("ands_hold", {24'd0, sb_out}, 32'h30);
    check("ands_acr", {31'd0, u_if.acr}, 32'd0);
    check("ands_avr", {31'd0, u_if.avr}, 32'd0);
    pulse(3'd2, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("eors_hold", {24'd0, sb_out}, 32'hCC);
    pulse(3'd6, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    check("rsvd_hold", {24'd0, sb_out}, 32'h00);
    check("rsvd_done", {31'd0, u_if.done}, 32'd1);
    // bcd is ignored for non-SUMS ops
    pulse(3'd3, 8'h0A, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ors_bcd_done", {31'd0, u_if.done}, 32'd1);
    check("ors_bcd_hold", {24'd0, sb_out}, 32'h0A);
    tick();

    // Start during ADJ with new operands is dropped
    pulse(3'd0, 8'h58, 8'h46, 1'b1, 1'b1, 1'b0);
    set_op(3'd1, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    check("drop_done", {31'd0, u_if.done}, 32'd1);
    check("drop_hold", {24'd0, sb_out}, 32'h05);
    tick();
    check("drop_done0", {31'd0, u_if.done}, 32'd0);
    check("drop_hold_keep", {24'd0, sb_out}, 32'h05);

    // Continuous start with ORS: new result every cycle, done held
    set_op(3'd3, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    u_if.start = 1'b1;
    tick();
    check("b2b1_hold", {24'd0, sb_out}, 32'h03);
    check("b2b1_done", {31'd0, u_if.done}, 32'd1);
    set_op(3'd3, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    tick();
    check("b2b2_hold", {24'd0, sb_out}, 32'h30);
    check("b2b2_done", {31'd0, u_if.done}, 32'd1);
    set_op(3'd3, 8'h80, 8'h04, 1'b0, 1'b0, 1'b0);
    tick();
    check("b2b3_hold", {24'd0, sb_out}, 32'h84);
    check("b2b3_adl", {24'd0, adl_out}, 32'h84);
    u_if.start = 1'b0;
    tick();
    check("b2b_done0", {31'd0, u_if.done}, 32'd0);

    // Reset asserted mid-ADJ aborts immediately
    pulse(3'd0, 8'h99, 8'h99, 1'b0, 1'b1, 1'b0);
    check("abort_busy", {31'd0, u_if.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_hold", {24'd0, adl_out}, 32'h00);
    check("abort_busy0", {31'd0, u_if.busy}, 32'd0);
    check("abort_acr", {31'd0, u_if.acr}, 32'd0);
    check("abort_avr", {31'd0, u_if.avr}, 32'd0);
    tick();
    check("abort_done", {31'd0, u_if.done}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort_done_after", {31'd0, u_if.done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
